// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants for the seven-segment test_value display
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns; element 0 is the glyph for nibble 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational nibble to active-low segment decoder
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/test_value_display.sv
// rtl/test_value_display.sv - 8-digit multiplexed hex display of the 32-bit test_value bus
module test_value_display
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] test_value,
  input  logic        freeze,
  input  logic        blank_en,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   snap_q, snap_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_tick_q, frame_tick_d;

  logic          tick;
  logic          wrap;
  logic [3:0]    nib;
  logic [6:0]    nib_seg;
  logic [31:0]   upper;
  logic          blank;

  assign tick  = (presc_q == PRESC_MAX);
  assign wrap  = tick && (idx_q == 3'd7);
  assign nib   = snap_q[{idx_q, 2'b00} +: 4];
  // Everything at or above the current digit; zero means this digit is a leading zero.
  assign upper = snap_q >> {idx_q, 2'b00};
  assign blank = blank_en && (idx_q != 3'd0) && (upper == 32'd0);

  hex_to_seg u_hex_to_seg (
    .nib (nib),
    .seg (nib_seg)
  );

  always_comb begin
    presc_d      = tick ? '0 : presc_q + 1'b1;
    idx_d        = tick ? idx_q + 3'd1 : idx_q;
    snap_d       = (wrap && !freeze) ? test_value : snap_q;
    frame_tick_d = wrap;
    an_d         = ~(8'b1 << idx_q);
    seg_d        = blank ? SEG_BLANK : nib_seg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= 3'd0;
      snap_q       <= 32'd0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_test_value_display.sv
// tb/tb_test_value_display.sv - directed self-checking bench for test_value_display
module tb_test_value_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] test_value;
  logic        freeze;
  logic        blank_en;
  logic [7:0]  an, an1;
  logic [6:0]  seg, seg1;
  logic        dp, dp1;
  logic        frame_tick, frame_tick1;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [7:0][6:0] f_zero, f_1234, f_f0, f_z_bl, f_1, f_2, f_3, f_4;

  test_value_display #(.REFRESH_DIV(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .test_value (test_value),
    .freeze     (freeze),
    .blank_en   (blank_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  test_value_display #(.REFRESH_DIV(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .test_value (test_value),
    .freeze     (freeze),
    .blank_en   (blank_en),
    .an         (an1),
    .seg        (seg1),
    .dp         (dp1),
    .frame_tick (frame_tick1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One full 32-cycle frame starting right after a frame boundary (or reset release).
  // Optionally drives test_value/freeze just before slot (ev_d, ev_c).
  task automatic check_frame(input logic [7:0][6:0] exp, input string tag,
                             input int ev_d, input int ev_c,
                             input logic [31:0] ev_tv, input logic ev_frz,
                             input bit chk1);
    logic [7:0] exp_an;
    logic [7:0] exp_an1;
    logic       exp_ft;
    int         s;
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (d == ev_d && c == ev_c) begin
          test_value = ev_tv;
          freeze     = ev_frz;
        end
        step();
        s      = 4 * d + c + 1;
        exp_an = ~(8'b1 << d);
        exp_ft = (d == 7 && c == 3);
        chk($sformatf("%s d%0d c%0d an", tag, d, c), {24'd0, an}, {24'd0, exp_an});
        chk($sformatf("%s d%0d c%0d seg", tag, d, c), {25'd0, seg}, {25'd0, exp[d]});
        chk($sformatf("%s d%0d c%0d frame_tick", tag, d, c), {31'd0, frame_tick}, {31'd0, exp_ft});
        if (chk1) begin
          exp_an1 = ~(8'b1 << ((s - 1) % 8));
          chk($sformatf("%s div1 s%0d an", tag, s), {24'd0, an1}, {24'd0, exp_an1});
          chk($sformatf("%s div1 s%0d seg", tag, s), {25'd0, seg1}, 32'h40);
          chk($sformatf("%s div1 s%0d frame_tick", tag, s), {31'd0, frame_tick1},
              {31'd0, (s % 8 == 0)});
        end
      end
    end
  endtask

  initial begin
    f_zero = {8{7'h40}};
    f_1234 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21};
    f_f0   = {{6{7'h7F}}, 7'h0E, 7'h40};
    f_z_bl = {{7{7'h7F}}, 7'h40};
    f_1    = {8{7'h79}};
    f_2    = {8{7'h24}};
    f_3    = {8{7'h30}};
    f_4    = {8{7'h19}};

    reset      = 1'b1;
    test_value = 32'h1234_ABCD;
    freeze     = 1'b0;
    blank_en   = 1'b0;
    step();
    step();
    chk("reset an", {24'd0, an}, 32'hFF);
    chk("reset seg", {25'd0, seg}, 32'h7F);
    chk("reset dp", {31'd0, dp}, 32'h1);
    chk("reset frame_tick", {31'd0, frame_tick}, 32'h0);
    chk("reset div1 an", {24'd0, an1}, 32'hFF);

    reset = 1'b0;
    check_frame(f_zero, "frame0", -1, 0, 32'h0, 1'b0, 1'b0);

    test_value = 32'h0000_00F0;
    blank_en   = 1'b1;
    check_frame(f_1234, "frame1", -1, 0, 32'h0, 1'b0, 1'b0);

    test_value = 32'h0;
    check_frame(f_f0, "blank_f0", -1, 0, 32'h0, 1'b0, 1'b0);

    test_value = 32'h1111_1111;
    check_frame(f_z_bl, "blank_zero", -1, 0, 32'h0, 1'b0, 1'b0);

    // Mid-frame change at idx=3 must not leak into the current frame.
    check_frame(f_1, "coh_old", 3, 0, 32'h2222_2222, 1'b0, 1'b0);

    // Freeze one cycle before the wrap tick, hold for three frames.
    check_frame(f_2, "coh_new", 7, 2, 32'h3333_3333, 1'b1, 1'b0);
    check_frame(f_2, "frz_a1", -1, 0, 32'h0, 1'b0, 1'b0);
    check_frame(f_2, "frz_a2", -1, 0, 32'h0, 1'b0, 1'b0);
    check_frame(f_2, "frz_a3", 7, 3, 32'h3333_3333, 1'b0, 1'b0);

    // Freeze in the same cycle as the wrap tick.
    check_frame(f_3, "unfrz_a", 7, 3, 32'h4444_4444, 1'b1, 1'b0);
    check_frame(f_3, "frz_b", 7, 3, 32'h4444_4444, 1'b0, 1'b0);

    for (int s = 0; s < 20; s++) begin
      step();
      chk($sformatf("unfrz_b s%0d seg", s), {25'd0, seg}, 32'h19);
    end
    test_value = 32'h0;
    blank_en   = 1'b0;
    reset      = 1'b1;
    step();
    chk("midrst an", {24'd0, an}, 32'hFF);
    chk("midrst seg", {25'd0, seg}, 32'h7F);
    chk("midrst frame_tick", {31'd0, frame_tick}, 32'h0);
    chk("midrst dp", {31'd0, dp}, 32'h1);
    chk("midrst div1 an", {24'd0, an1}, 32'hFF);

    reset = 1'b0;
    check_frame(f_zero, "post_rst", -1, 0, 32'h0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/test_value_display.md
Name: test_value_display

Overview:
- Downstream consumer of the datapath's 32-bit test_value bus. It drives an 8-digit, common-anode, multiplexed seven-segment display.
- Shows the value as 8 hex digits, time-multiplexed one digit per refresh slot.
- Captures a coherent snapshot once per scan frame, so digits never mix old and new values.
- Optional leading-zero blanking and freeze input, used for board bring-up of the single-cycle core.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot. Must be >= 1. Prescaler width is max(1, clog2(REFRESH_DIV)).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- test_value  input  32  value from datapath; sampled only at frame boundaries
- freeze  input  1  1 = hold current snapshot; scanning continues
- blank_en  input  1  1 = blank leading zero digits
- an  output  8  digit enables, active low; an[k] selects digit k (k=0 is the least significant nibble)
- seg  output  7  segments {g,f,e,d,c,b,a}, active low
- dp  output  1  decimal point, active low; always 1 (off)
- frame_tick  output  1  one-cycle pulse when a new frame starts (snapshot load slot)

Behaviour:
- Reset (synchronous, active-high, dominant over all other inputs):
  - prescaler=0, digit index idx=0, snapshot=0.
  - an=8'hFF, seg=7'h7F, dp=1, frame_tick=0.
  - Applies mid-frame too: the scan restarts at digit 0 and the snapshot clears.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick is high in the cycle where prescaler==REFRESH_DIV-1.
  - With REFRESH_DIV=1, tick is high every cycle.
- Digit index: on tick, idx <= idx+1 (mod 8), so 7 wraps to 0.
- Snapshot:
  - On the tick where idx==7 (the wrap), snapshot <= test_value unless freeze==1, in which case it holds.
  - frame_tick is registered: it is high for exactly one cycle, the cycle after that tick. It pulses on every wrap regardless of freeze.
- Outputs (all registered, one cycle of latency after idx/snapshot change):
  - an <= ~(8'b1 << idx).
  - nib = snapshot[4*idx+3 : 4*idx].
  - seg <= hex pattern of nib, or 7'h7F if the digit is blanked.
- Blanking: digit k (k>=1) is blanked iff blank_en==1 and snapshot[31:4k]==0. Digit 0 is never blanked, so value 0 shows a single "0".
- Hex patterns (seg, gfedcba, active low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Timing and simultaneous events:
  - First lit digit appears on the cycle after reset deasserts: an=FE, seg=40.
  - test_value changes mid-frame have no visible effect until the next wrap.
  - freeze asserted in the same cycle as the wrap tick blocks that load.
  - blank_en is combinationally applied to the registered output each cycle, so a change takes effect on the next clock.

Decomposition:
- Shared package (display_pkg):
  - 16-entry hex-to-segment constant table.
  - SEG_BLANK=7'h7F and AN_OFF=8'hFF constants.
- One combinational sub-module hex_to_seg (4-bit nibble in, 7-bit seg out), instantiated once on the selected nibble.
- Prescaler, idx, snapshot and output registers live in the top.

Test Plan (bench uses REFRESH_DIV=4):
- Reset, then release with test_value=32'h1234ABCD, blank_en=0:
  - first frame shows snapshot 0: an cycles FE,FD,...,7F with seg=40 each, 4 cycles per digit.
  - after the wrap, digit0 seg=21 (d), digit1 46 (C), digit2 03 (b), digit3 08 (A), digit4 19, digit5 30, digit6 24, digit7 79.
- Blanking: test_value=32'h0000_00F0, blank_en=1:
  - digit0=40, digit1=0E, digits2..7 seg=7F while the corresponding an bit is 0.
  - test_value=0 gives digit0=40 and all others 7F.
- Frame coherence: change test_value from 32'h11111111 to 32'h22222222 while idx=3:
  - digits 3..7 of the current frame still show 79.
  - the next frame shows 24 on all digits.
  - frame_tick pulses exactly once per 32 cycles.
- Freeze: set freeze=1 one cycle before a wrap tick (and, separately, in the same cycle as the tick), then change test_value:
  - snapshot is held across 3 frames, and frame_tick still pulses.
  - after freeze=0, the new value appears from the next frame.
- Reset mid-frame: assert reset at idx=5:
  - next cycle an=FF, seg=7F, frame_tick=0.
  - after release, scanning restarts at an=FE with snapshot 0 (seg=40).
- REFRESH_DIV=1 build: idx advances every cycle, frame_tick has period 8, and an rotates FE→FD→…→7F→FE.
